// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// field widths and the running-checksum helper.
package loader_pkg;

  localparam int LEN_W  = 11;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CSUM    = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembly for the program loader: high-byte latch, write address
// counter, remaining-word counter and the registered instruction-memory write port.
module loader_word_asm
  import loader_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               len_load_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               hi_load_i,
  input  logic               lo_load_i,
  input  logic [BYTE_W-1:0]  byte_i,
  output logic               last_o,
  output logic               wr_en_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [INSTR_W-1:0] wr_data_o
);

  logic [INSTR_W-BYTE_W-1:0] hi_q, hi_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [LEN_W-1:0]          rem_q, rem_d;
  logic                      wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0]        wr_data_q, wr_data_d;

  // The word being completed by a low byte is the last one of the image.
  assign last_o = (rem_q == LEN_W'(1));

  // Next-state for the assembly register, counters and write port.
  always_comb begin
    hi_d      = hi_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (clear_i) begin
      addr_d = '0;
      rem_d  = '0;
    end else if (len_load_i) begin
      rem_d = len_i;
    end else if (hi_load_i) begin
      hi_d = byte_i;
    end else if (lo_load_i) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = {hi_q, byte_i};
      // Address wraps naturally to 0 after the 1024th word.
      addr_d    = addr_q + ADDR_W'(1);
      rem_d     = rem_q - LEN_W'(1);
    end else begin
      hi_d = hi_q;
    end
  end

  // Register stage for assembly state and write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q      <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length/words/checksum byte frame, writes instruction
// memory and holds the core in reset until the image is accepted. Optional
// checksum comparison is enabled with `define CSUM_CHECK_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int INSTR_W   = 16,
  parameter int MAX_WORDS = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_wr_en,
  output logic [ADDR_W-1:0]  imem_wr_addr,
  output logic [INSTR_W-1:0] imem_wr_data,
  output logic               core_hold,
  output logic               load_done,
  output logic               load_error
);

  localparam logic [LEN_W-1:0] MAX_N = LEN_W'(MAX_WORDS);

  state_e           state_q, state_d;
  logic [2:0]       len_hi_q, len_hi_d;
  logic             rx_ready_q, rx_ready_d;
  logic             core_hold_q, core_hold_d;
  logic             load_done_q, load_done_d;
  logic             load_error_q, load_error_d;
  logic             xfer_s, start_load_s, len_load_s, hi_load_s, lo_load_s, last_s;
  logic [LEN_W-1:0] n_s;
  logic             csum_ok_s;

  assign xfer_s = rx_valid & rx_ready_q;
  assign n_s    = {len_hi_q, rx_data};

`ifdef CSUM_CHECK_EN
  logic [BYTE_W-1:0] csum_q, csum_d;

  // Running sum of every data byte; cleared when a new load starts.
  always_comb begin
    csum_d = csum_q;
    if (start_load_s) begin
      csum_d = '0;
    end else if (hi_load_s || lo_load_s) begin
      csum_d = csum_add(csum_q, rx_data);
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign csum_ok_s = (rx_data == csum_q);
`else
  assign csum_ok_s = 1'b1;
`endif

  // Frame sequencing and load strobes to the word assembler.
  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    start_load_s = 1'b0;
    len_load_s   = 1'b0;
    hi_load_s    = 1'b0;
    lo_load_s    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d      = ST_LEN_HI;
          start_load_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        if (xfer_s) begin
          len_hi_d = rx_data[2:0];
          state_d  = ST_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (xfer_s) begin
          len_load_s = 1'b1;
          if (n_s > MAX_N)             state_d = ST_ERROR;
          else if (n_s == LEN_W'(0))   state_d = ST_CSUM;
          else                         state_d = ST_DATA_HI;
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA_HI: begin
        if (xfer_s) begin
          hi_load_s = 1'b1;
          state_d   = ST_DATA_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA_LO: begin
        if (xfer_s) begin
          lo_load_s = 1'b1;
          state_d   = last_s ? ST_CSUM : ST_DATA_HI;
        end else begin
          state_d = state_q;
        end
      end
      ST_CSUM: begin
        if (xfer_s) state_d = csum_ok_s ? ST_DONE : ST_ERROR;
        else        state_d = state_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered with it.
  always_comb begin
    rx_ready_d   = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                   (state_d == ST_DATA_HI) || (state_d == ST_DATA_LO) ||
                   (state_d == ST_CSUM);
    core_hold_d  = (state_d != ST_DONE);
    load_done_d  = (state_d == ST_DONE);
    load_error_d = (state_d == ST_ERROR);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= 3'd0;
      rx_ready_q   <= 1'b0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      rx_ready_q   <= rx_ready_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  loader_word_asm #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_word_asm (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clear_i    (start_load_s),
    .len_load_i (len_load_s),
    .len_i      (n_s),
    .hi_load_i  (hi_load_s),
    .lo_load_i  (lo_load_s),
    .byte_i     (rx_data),
    .last_o     (last_s),
    .wr_en_o    (imem_wr_en),
    .wr_addr_o  (imem_wr_addr),
    .wr_data_o  (imem_wr_data)
  );

  assign rx_ready   = rx_ready_q;
  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of frames, random frames against
// a frame-level reference model, and hand-written reset / restart sequences.
module tb_program_loader;

  localparam int ADDR_W    = 10;
  localparam int INSTR_W   = 16;
  localparam int MAX_WORDS = 1024;
`ifdef CSUM_CHECK_EN
  localparam bit CSUM_CHK = 1'b1;
`else
  localparam bit CSUM_CHK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_valid = 1'b0;
  logic               rx_ready, imem_wr_en, core_hold, load_done, load_error;
  logic [ADDR_W-1:0]  imem_wr_addr;
  logic [INSTR_W-1:0] imem_wr_data;

  int checks = 0;
  int failures = 0;

  program_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .core_hold(core_hold), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  // Captured memory writes.
  logic [ADDR_W-1:0]  wq_addr[$];
  logic [INSTR_W-1:0] wq_data[$];

  always @(negedge clk) begin
    if (imem_wr_en) begin
      wq_addr.push_back(imem_wr_addr);
      wq_data.push_back(imem_wr_data);
    end
  end

  typedef struct {
    logic [7:0]  lh;
    logic [7:0]  ll;
    logic [15:0] w0, w1, w2;
    int          pat;      // 0 explicit words, 1 data = address, 2 random
    bit          bad;      // corrupt checksum
    int          gap;      // idle cycles before every byte
    bit          stray;    // pulse start with the first data byte
    bit          exp_done;
    int          exp_writes;
  } vec_t;

  vec_t tab[8];

  function automatic vec_t mk(input logic [7:0] lh, input logic [7:0] ll,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input int pat, input bit bad,
                              input int gap, input bit stray, input bit exp_done,
                              input int exp_writes);
    vec_t v;
    v.lh = lh; v.ll = ll; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.pat = pat;
    v.bad = bad; v.gap = gap; v.stray = stray; v.exp_done = exp_done;
    v.exp_writes = exp_writes;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"},   rx_ready, 0);
    check({tag, "_wr_en"},      imem_wr_en, 0);
    check({tag, "_wr_addr"},    imem_wr_addr, 0);
    check({tag, "_wr_data"},    imem_wr_data, 0);
    check({tag, "_core_hold"},  core_hold, 1);
    check({tag, "_load_done"},  load_done, 0);
    check({tag, "_load_error"}, load_error, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    bit sent = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    start    = with_start;
    for (int t = 0; t < 50 && !sent; t++) begin
      if (rx_ready) begin
        @(posedge clk);
        #1;
        sent = 1'b1;
      end else begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    if (!sent) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout actual=not_accepted required=accepted byte=0x%02h", b);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Frame-level reference: N from the length bytes, words from the pattern,
  // checksum = sum of data bytes mod 256.
  task automatic run_frame(input vec_t v, input string name);
    logic [15:0] words[$];
    int          n;
    bit          over;
    logic [7:0]  sum;
    n    = int'(v.lh[2:0]) * 256 + int'(v.ll);
    over = (n > MAX_WORDS);
    sum  = 8'h00;
    for (int i = 0; i < n && !over; i++) begin
      logic [15:0] w;
      case (v.pat)
        0:       w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : v.w2;
        1:       w = 16'(i);
        default: w = 16'($urandom);
      endcase
      words.push_back(w);
      sum = sum + w[15:8] + w[7:0];
    end
    if (v.bad) sum = sum + 8'd1;

    // Bytes offered while not ready must be ignored.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    @(negedge clk);
    check({name, "_ready_low_between_loads"}, rx_ready, 0);
    rx_valid = 1'b0;

    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    check({name, "_start_core_hold"}, core_hold, 1);
    check({name, "_start_load_done"}, load_done, 0);
    check({name, "_start_load_error"}, load_error, 0);
    check({name, "_start_rx_ready"}, rx_ready, 1);

    send_byte(v.lh, v.gap, 1'b0);
    send_byte(v.ll, v.gap, 1'b0);
    if (!over) begin
      foreach (words[i]) begin
        send_byte(words[i][15:8], v.gap, v.stray && (i == 0));
        send_byte(words[i][7:0], v.gap, 1'b0);
      end
      send_byte(sum, v.gap, 1'b0);
    end
    @(negedge clk);
    check({name, "_load_done"},  load_done, 32'(v.exp_done));
    check({name, "_load_error"}, load_error, 32'(!v.exp_done));
    check({name, "_core_hold"},  core_hold, 32'(!v.exp_done));
    check({name, "_rx_ready_end"}, rx_ready, 0);
    repeat (2) @(negedge clk);
    check({name, "_write_count"}, wq_addr.size(), v.exp_writes);
    for (int i = 0; i < wq_addr.size() && i < words.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), wq_addr[i], i % (1 << ADDR_W));
      check($sformatf("%s_data%0d", name, i), wq_data[i], words[i]);
    end
  endtask

  initial begin
    vec_t rv;
    tab[0] = mk(8'h00, 8'h02, 16'h1234, 16'hABCD, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b1, 2);
    tab[1] = mk(8'h00, 8'h02, 16'h1234, 16'hABCD, 16'h0000, 0, 1'b1, 0, 1'b0, !CSUM_CHK, 2);
    tab[2] = mk(8'h04, 8'h01, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    tab[3] = mk(8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b1, 0);
    tab[4] = mk(8'h00, 8'h03, 16'h0102, 16'h0304, 16'h0506, 0, 1'b0, 1, 1'b0, 1'b1, 3);
    tab[5] = mk(8'hF8, 8'h03, 16'hBEEF, 16'hCAFE, 16'hF00D, 0, 1'b0, 0, 1'b1, 1'b1, 3);
    tab[6] = mk(8'h04, 8'h00, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0, 0, 1'b0, 1'b1, 1024);
    tab[7] = mk(8'h07, 8'hFF, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0, 0);

    #2 reset = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(tab[i], $sformatf("vec%0d", i));

    // Reset in the middle of a load, after the high byte of word 1.
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_reset_outputs("midreset");
    check("midreset_writes_before", wq_addr.size(), 1);
    @(negedge clk);
    reset = 1'b1;
    run_frame(tab[0], "after_reset");

    // Random frames checked against the frame-level model.
    for (int r = 0; r < 24; r++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_WORDS + 1, 2047)
                                      : $urandom_range(0, 6);
      rv = mk({5'($urandom), 3'(n >> 8)}, 8'(n), 16'h0, 16'h0, 16'h0, 2,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2), $urandom_range(0, 1) == 1,
              1'b0, 0);
      rv.exp_done   = (n <= MAX_WORDS) && !(CSUM_CHK && rv.bad);
      rv.exp_writes = (n <= MAX_WORDS) ? n : 0;
      run_frame(rv, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
